// File: rtl/mem_map_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_map_pkg - bus region codes and timer register map shared by HW/SW |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mem_map_pkg;

    localparam logic [3:0] REG_RAM   = 4'h0;
    localparam logic [3:0] REG_LEDR  = 4'h1;
    localparam logic [3:0] REG_HEX   = 4'h2;
    localparam logic [3:0] REG_SW    = 4'h3;
    localparam logic [3:0] REG_TIMER = 4'h4;

    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_LOAD   = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;
    localparam logic [1:0] TMR_STATUS = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_AUTO_BIT = 1;

    localparam int HEX_COUNT = 6;

    function automatic logic [3:0] region_of(input logic [15:0] a);
        return a[15:12];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_io_responder_io_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | io_timer - prescaled down-counter with reload and sticky expiry flag  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module io_timer
    import mem_map_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int PRESCALE = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_we,
    input  logic [1:0]        i_off,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_irq
);

    localparam int             PW      = $clog2(PRESCALE);
    localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

    logic [1:0]        r_ctrl;
    logic [DATA_W-1:0] r_load;
    logic [DATA_W-1:0] r_count;
    logic [PW-1:0]     r_presc;
    logic              r_expired;
    logic              r_irq;

    logic w_en, w_auto, w_tick;
    logic w_ctrl_wr, w_load_wr, w_status_wr;
    logic w_expire, w_expired_nxt;

    assign w_en        = r_ctrl[CTRL_EN_BIT];
    assign w_auto      = r_ctrl[CTRL_AUTO_BIT];
    assign w_tick      = w_en && (r_presc == PS_LAST);
    assign w_ctrl_wr   = i_we && (i_off == TMR_CTRL);
    assign w_load_wr   = i_we && (i_off == TMR_LOAD);
    assign w_status_wr = i_we && (i_off == TMR_STATUS);

    // A LOAD write pre-empts any tick on the same edge, so it also blocks expiry.
    assign w_expire      = w_tick && !w_load_wr && (r_count == DATA_W'(1));
    assign w_expired_nxt = w_expire | (r_expired & ~w_status_wr);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ctrl    <= '0;
            r_load    <= '0;
            r_count   <= '0;
            r_presc   <= '0;
            r_expired <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_ctrl <= i_wdata[1:0];
            end
            if (w_load_wr) begin
                r_load  <= i_wdata;
                r_count <= i_wdata;
                r_presc <= '0;
            end else begin
                if (!w_en || w_tick) begin
                    r_presc <= '0;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
                if (w_tick && (r_count != '0)) begin
                    if (r_count == DATA_W'(1)) begin
                        r_count <= w_auto ? r_load : '0;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
            end
            r_expired <= w_expired_nxt;
            r_irq     <= w_expired_nxt;
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_off)
            TMR_CTRL:   o_rdata = DATA_W'(r_ctrl);
            TMR_LOAD:   o_rdata = r_load;
            TMR_COUNT:  o_rdata = r_count;
            TMR_STATUS: o_rdata = DATA_W'(r_expired);
            default:    o_rdata = '0;
        endcase
    end

    assign o_irq = r_irq;

endmodule
`default_nettype wire

// File: rtl/mem_io_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_io_responder - CPU memory-bus responder: RAM, LEDR, HEX, SW, timer|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_io_responder
    import mem_map_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int RAM_AW   = 8,
    parameter int PRESCALE = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              w,
    output logic [DATA_W-1:0] rdata,
    input  logic [9:0]        sw,
    output logic [9:0]        ledr,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3,
    output logic [6:0]        hex4,
    output logic [6:0]        hex5,
    output logic              irq
);

    logic [DATA_W-1:0] r_ram [2**RAM_AW];
    logic [DATA_W-1:0] r_rdata;
    logic [9:0]        r_ledr;
    logic [6:0]        r_hex [HEX_COUNT];
    logic [9:0]        r_sw_meta;
    logic [9:0]        r_sw_sync;

    logic [3:0]        w_region;
    logic [2:0]        w_hex_idx;
    logic              w_hex_ok;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic [DATA_W-1:0] w_tmr_rdata;
    logic              w_tmr_we;
    logic              w_unused;

    assign w_region  = region_of(addr);
    assign w_hex_idx = addr[2:0];
    assign w_hex_ok  = (w_hex_idx < 3'(HEX_COUNT));
    assign w_tmr_we  = w && (w_region == REG_TIMER);
    assign w_unused  = ^addr;

    // RAM is deliberately left out of reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (w && (w_region == REG_RAM)) begin
            r_ram[addr[RAM_AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rdata   <= '0;
            r_ledr    <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            for (int i = 0; i < HEX_COUNT; i++) begin
                r_hex[i] <= 7'h7F;
            end
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            r_rdata   <= w_rdata_nxt;
            if (w && (w_region == REG_LEDR)) begin
                r_ledr <= wdata[9:0];
            end
            if (w && (w_region == REG_HEX) && w_hex_ok) begin
                r_hex[w_hex_idx] <= wdata[6:0];
            end
        end
    end

    // Mux uses pre-edge state, so same-edge writes return old contents.
    always_comb begin
        w_rdata_nxt = '0;
        case (w_region)
            REG_RAM:   w_rdata_nxt = r_ram[addr[RAM_AW-1:0]];
            REG_LEDR:  w_rdata_nxt = DATA_W'(r_ledr);
            REG_HEX:   w_rdata_nxt = w_hex_ok ? DATA_W'(r_hex[w_hex_idx]) : '0;
            REG_SW:    w_rdata_nxt = DATA_W'(r_sw_sync);
            REG_TIMER: w_rdata_nxt = w_tmr_rdata;
            default:   w_rdata_nxt = '0;
        endcase
    end

    io_timer #(
        .DATA_W   (DATA_W),
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_tmr_we),
        .i_off   (addr[1:0]),
        .i_wdata (wdata),
        .o_rdata (w_tmr_rdata),
        .o_irq   (irq)
    );

    assign rdata = r_rdata;
    assign ledr  = r_ledr;
    assign hex0  = r_hex[0];
    assign hex1  = r_hex[1];
    assign hex2  = r_hex[2];
    assign hex3  = r_hex[3];
    assign hex4  = r_hex[4];
    assign hex5  = r_hex[5];

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_io_responder - directed vector bench for mem_io_responder      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_io_responder;

    logic        clk;
    logic        reset_n;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        w;
    logic [15:0] rdata;
    logic [9:0]  sw;
    logic [9:0]  ledr;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [41:0] H0 = {6{7'h7F}};
    localparam logic [41:0] H3 = {7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h7F, 7'h7F};

    mem_io_responder #(
        .DATA_W   (16),
        .RAM_AW   (8),
        .PRESCALE (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr),
        .wdata   (wdata),
        .w       (w),
        .rdata   (rdata),
        .sw      (sw),
        .ledr    (ledr),
        .hex0    (hex0),
        .hex1    (hex1),
        .hex2    (hex2),
        .hex3    (hex3),
        .hex4    (hex4),
        .hex5    (hex5),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        w;
        logic        chk_r;
        logic [15:0] rdata;
        logic [9:0]  ledr;
        logic [41:0] hex;
    } vec_t;

    vec_t vecs[18];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic we);
        addr  = a;
        wdata = d;
        w     = we;
    endtask

    initial begin
        vecs[0]  = '{16'h0005, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 10'h000, H0};
        vecs[1]  = '{16'h0005, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 10'h000, H0};
        vecs[2]  = '{16'h0105, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 10'h000, H0};
        vecs[3]  = '{16'h0010, 16'h1111, 1'b1, 1'b0, 16'h0000, 10'h000, H0};
        vecs[4]  = '{16'h0010, 16'h2222, 1'b1, 1'b1, 16'h1111, 10'h000, H0};
        vecs[5]  = '{16'h0010, 16'h0000, 1'b0, 1'b1, 16'h2222, 10'h000, H0};
        vecs[6]  = '{16'h1000, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 10'h3FF, H0};
        vecs[7]  = '{16'h1000, 16'h0000, 1'b0, 1'b1, 16'h03FF, 10'h3FF, H0};
        vecs[8]  = '{16'h2003, 16'h0040, 1'b1, 1'b1, 16'h007F, 10'h3FF, H3};
        vecs[9]  = '{16'h2003, 16'h0000, 1'b0, 1'b1, 16'h0040, 10'h3FF, H3};
        vecs[10] = '{16'h2006, 16'h0000, 1'b1, 1'b1, 16'h0000, 10'h3FF, H3};
        vecs[11] = '{16'h2000, 16'h0000, 1'b0, 1'b1, 16'h007F, 10'h3FF, H3};
        vecs[12] = '{16'h9005, 16'h1234, 1'b1, 1'b1, 16'h0000, 10'h3FF, H3};
        vecs[13] = '{16'h9000, 16'h0000, 1'b0, 1'b1, 16'h0000, 10'h3FF, H3};
        vecs[14] = '{16'h3005, 16'h5555, 1'b1, 1'b1, 16'h0000, 10'h3FF, H3};
        vecs[15] = '{16'h4002, 16'h0007, 1'b1, 1'b1, 16'h0000, 10'h3FF, H3};
        vecs[16] = '{16'h4002, 16'h0000, 1'b0, 1'b1, 16'h0000, 10'h3FF, H3};
        vecs[17] = '{16'h0005, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 10'h3FF, H3};

        reset_n = 1'b0;
        sw      = 10'h000;
        drive(16'h0000, 16'h0000, 1'b0);
        tick();
        tick();
        chk("reset_rdata", 64'(rdata), 64'h0);
        chk("reset_ledr", 64'(ledr), 64'h0);
        chk("reset_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(H0));
        chk("reset_irq", 64'(irq), 64'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].w);
            tick();
            if (vecs[i].chk_r) chk($sformatf("vec%0d_rdata", i), 64'(rdata), 64'(vecs[i].rdata));
            chk($sformatf("vec%0d_ledr", i), 64'(ledr), 64'(vecs[i].ledr));
            chk($sformatf("vec%0d_hex", i), 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(vecs[i].hex));
        end

        // Switch synchronizer latency
        drive(16'h3000, 16'h0000, 1'b0);
        sw = 10'h2A5;
        tick();
        chk("sw_edge1", 64'(rdata), 64'h0);
        tick();
        chk("sw_edge2", 64'(rdata), 64'h0);
        tick();
        chk("sw_edge3", 64'(rdata), 64'h02A5);

        // One-shot countdown: LOAD=3, CTRL=EN
        drive(16'h4001, 16'h0003, 1'b1);
        tick();
        drive(16'h4000, 16'h0001, 1'b1);
        tick();
        for (int k = 1; k <= 20; k++) begin
            drive(16'h4002, 16'h0000, 1'b0);
            tick();
            chk($sformatf("oneshot_irq_k%0d", k), 64'(irq), 64'(k >= 12));
            if (k == 5)  chk("oneshot_count_k5", 64'(rdata), 64'd2);
            if (k == 9)  chk("oneshot_count_k9", 64'(rdata), 64'd1);
            if (k == 13) chk("oneshot_count_k13", 64'(rdata), 64'd0);
            if (k == 20) chk("oneshot_count_k20", 64'(rdata), 64'd0);
        end
        drive(16'h4003, 16'h0000, 1'b1);
        tick();
        chk("status_clear_irq", 64'(irq), 64'h0);

        // Auto-reload: CTRL=0, LOAD=3, CTRL=EN|AUTO
        drive(16'h4000, 16'h0000, 1'b1);
        tick();
        drive(16'h4001, 16'h0003, 1'b1);
        tick();
        drive(16'h4000, 16'h0003, 1'b1);
        tick();
        for (int k = 1; k <= 40; k++) begin
            if (k == 13 || k == 25 || k == 36) drive(16'h4003, 16'h0000, 1'b1);
            else if (k == 14)                 drive(16'h4002, 16'h0000, 1'b0);
            else                              drive(16'h4003, 16'h0000, 1'b0);
            tick();
            chk($sformatf("auto_irq_k%0d", k), 64'(irq), 64'(k == 12 || k == 24 || k >= 36));
            if (k == 14) chk("auto_reload_count", 64'(rdata), 64'd3);
        end

        // Reset in the middle of a countdown
        reset_n = 1'b0;
        drive(16'h0005, 16'h0000, 1'b0);
        tick();
        reset_n = 1'b1;
        chk("midreset_irq", 64'(irq), 64'h0);
        chk("midreset_ledr", 64'(ledr), 64'h0);
        chk("midreset_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(H0));
        chk("midreset_rdata", 64'(rdata), 64'h0);
        drive(16'h4002, 16'h0000, 1'b0);
        tick();
        chk("midreset_count", 64'(rdata), 64'h0);
        drive(16'h4000, 16'h0000, 1'b0);
        tick();
        chk("midreset_ctrl", 64'(rdata), 64'h0);
        drive(16'h4003, 16'h0000, 1'b0);
        tick();
        chk("midreset_status", 64'(rdata), 64'h0);
        drive(16'h0005, 16'h0000, 1'b0);
        tick();
        chk("midreset_ram_kept", 64'(rdata), 64'hBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
